// File: rtl/muldiv_seq_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div sequencer.
// The master is the EX stage; the slave is muldiv_seq.
interface muldiv_seq_if;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        annul;
  logic        ex_hold;
  logic        stallreq;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  modport master (
    output op_valid, op_code, src_a, src_b, annul, ex_hold,
    input  stallreq, busy, hilo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b, annul, ex_hold,
    output stallreq, busy, hilo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/muldiv_seq.sv
// EX-stage sequencer for mult/multu/div/divu: latches operands, drives the mul/div units,
// stalls EX until done, then issues one HI/LO write. Option: MULDIV_DIV_ZERO_FAST_EN.
module muldiv_seq #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave ex_if,
  output logic        mul_signed_o,
  output logic [31:0] mul_ina_o,
  output logic [31:0] mul_inb_o,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_annul_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        stallreq_c;
  logic        hilo_we_c;
  logic [31:0] hi_wdata_c;
  logic [31:0] lo_wdata_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      op_q    <= 2'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    op_d          = op_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    stallreq_c    = 1'b0;
    hilo_we_c     = 1'b0;
    hi_wdata_c    = 32'd0;
    lo_wdata_c    = 32'd0;
    mul_signed_o  = 1'b0;
    mul_ina_o     = 32'd0;
    mul_inb_o     = 32'd0;
    div_start_o   = 1'b0;
    div_signed_o  = 1'b0;
    div_opdata1_o = 32'd0;
    div_opdata2_o = 32'd0;
    div_annul_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The stall must be raised in the acceptance cycle itself, but never while in reset.
        if (ex_if.op_valid && !ex_if.annul && !rst) begin
          stallreq_c = 1'b1;
          opa_d      = ex_if.src_a;
          opb_d      = ex_if.src_b;
          op_d       = ex_if.op_code;
          if (!ex_if.op_code[1]) begin
            state_d = S_MUL_WAIT;
            cnt_d   = 4'(MUL_LATENCY - 1);
          end else begin
`ifdef MULDIV_DIV_ZERO_FAST_EN
            if (ex_if.src_b == 32'd0) begin
              hi_d    = ex_if.src_a;
              lo_d    = 32'hFFFF_FFFF;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV_WAIT;
            end
`else
            state_d = S_DIV_WAIT;
`endif
          end
        end
      end

      S_MUL_WAIT: begin
        mul_ina_o    = opa_q;
        mul_inb_o    = opb_q;
        mul_signed_o = (op_q == 2'b00);
        if (ex_if.annul) begin
          state_d = S_IDLE;
        end else begin
          stallreq_c = 1'b1;
          if (cnt_q == 4'd0) begin
            hi_d    = mul_result_i[63:32];
            lo_d    = mul_result_i[31:0];
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      S_DIV_WAIT: begin
        div_opdata1_o = opa_q;
        div_opdata2_o = opb_q;
        div_signed_o  = (op_q == 2'b10);
        // A flush beats a same-cycle div_ready: the result is dropped.
        if (ex_if.annul) begin
          div_annul_o = 1'b1;
          state_d     = S_IDLE;
        end else begin
          div_start_o = 1'b1;
          stallreq_c  = 1'b1;
          if (div_ready_i) begin
            hi_d    = div_result_i[63:32];
            lo_d    = div_result_i[31:0];
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        hi_wdata_c = hi_q;
        lo_wdata_c = lo_q;
        if (ex_if.annul) begin
          state_d = S_IDLE;
        end else begin
          hilo_we_c = 1'b1;
          state_d   = ex_if.ex_hold ? S_DRAIN : S_IDLE;
        end
      end

      S_DRAIN: begin
        // The finished op is still sitting in EX, so its op_valid must not restart us.
        if (ex_if.annul || !ex_if.ex_hold) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ex_if.stallreq = stallreq_c;
  assign ex_if.busy     = (state_q != S_IDLE);
  assign ex_if.hilo_we  = hilo_we_c;
  assign ex_if.hi_wdata = hi_wdata_c;
  assign ex_if.lo_wdata = lo_wdata_c;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: behavioural multiplier/divider models plus a HI/LO write scoreboard.
module tb_muldiv_seq;
  localparam int MUL_LAT = 2;   // multiplier model below has MUL_LAT-1 = 1 register stage
  localparam int DIV_CYC = 32;  // div_ready arrives in the 33rd div_start cycle

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result = 64'd0;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opdata1, div_opdata2;
  logic        div_ready = 1'b0;
  logic [63:0] div_result = 64'd0;

  muldiv_seq_if ex_if();

  muldiv_seq #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_if        (ex_if),
    .mul_signed_o (mul_signed),
    .mul_ina_o    (mul_ina),
    .mul_inb_o    (mul_inb),
    .mul_result_i (mul_result),
    .div_start_o  (div_start),
    .div_signed_o (div_signed),
    .div_opdata1_o(div_opdata1),
    .div_opdata2_o(div_opdata2),
    .div_annul_o  (div_annul),
    .div_ready_i  (div_ready),
    .div_result_i (div_result)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] ref_result(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb;
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    if (!code[1]) begin
      if (code[0]) begin
        pa = {32'd0, a};
        pb = {32'd0, b};
      end else begin
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
      end
      return pa * pb;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!code[0]) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Multiplier model: product visible one clock after the operands.
  logic [63:0] prod;
  always_comb prod = ref_result({1'b0, ~mul_signed}, mul_ina, mul_inb);
  always @(posedge clk) mul_result <= prod;

  // Divider model: result after DIV_CYC cycles of continuous div_start.
  int dcnt = 0;
  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (!div_start) begin
      dcnt <= 0;
    end else if (dcnt == DIV_CYC - 1) begin
      div_ready  <= 1'b1;
      div_result <= ref_result({1'b1, ~div_signed}, div_opdata1, div_opdata2);
      dcnt       <= 0;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  // Scoreboard: every HI/LO write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ex_if.hilo_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL hilo_write: got unexpected write hi=%h lo=%h, expected none", ex_if.hi_wdata, ex_if.lo_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({ex_if.hi_wdata, ex_if.lo_wdata} !== e) begin
          n_fail++;
          $display("FAIL hilo_write: got hi=%h lo=%h, expected hi=%h lo=%h", ex_if.hi_wdata, ex_if.lo_wdata, e[63:32], e[31:0]);
        end else begin
          $display("hilo write hi=%h lo=%h ok", ex_if.hi_wdata, ex_if.lo_wdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input string name, input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input int exp_starts, input int hold);
    int stalls = 0;
    int starts = 0;
    bit seen = 0;
    bit opd_bad = 0;
    @(posedge clk); #1;
    ex_if.op_valid = 1'b1;
    ex_if.op_code  = code;
    ex_if.src_a    = a;
    ex_if.src_b    = b;
    ex_if.ex_hold  = (hold > 0);
    exp_q.push_back(ref_result(code, a, b));
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (ex_if.stallreq) stalls++;
      if (div_start) begin
        starts++;
        if (div_opdata1 !== a || div_opdata2 !== b || div_signed !== (code == 2'b10)) opd_bad = 1;
      end
      if (!code[1] && ex_if.busy && ex_if.stallreq && mul_signed !== (code == 2'b00)) opd_bad = 1;
      if (ex_if.hilo_we) begin
        seen = 1;
        if (div_start !== 1'b0) opd_bad = 1;
      end else begin
        @(posedge clk); #1;
        ex_if.src_a = $urandom;
        ex_if.src_b = $urandom;
      end
    end
    n_vec++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no hilo_we within 200 cycles, expected one", name);
    end
    n_vec++;
    if (stalls !== exp_stall) begin
      n_fail++;
      $display("FAIL %s_stall: got %0d stall cycles, expected %0d", name, stalls, exp_stall);
    end
    n_vec++;
    if (starts !== exp_starts) begin
      n_fail++;
      $display("FAIL %s_div_start: got %0d div_start cycles, expected %0d", name, starts, exp_starts);
    end
    n_vec++;
    if (opd_bad) begin
      n_fail++;
      $display("FAIL %s_unit_ctrl: got wrong unit operand/sign/start, expected latched values", name);
    end
    @(posedge clk); #1;
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        n_vec++;
        if (ex_if.busy !== 1'b1 || ex_if.stallreq !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_drain: got busy=%b stallreq=%b, expected busy=1 stallreq=0", name, ex_if.busy, ex_if.stallreq);
        end
        @(posedge clk); #1;
      end
      ex_if.ex_hold = 1'b0;
      @(posedge clk); #1;
    end
    ex_if.op_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ex_if.busy !== 1'b0 || ex_if.stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got busy=%b stallreq=%b, expected 0 0", name, ex_if.busy, ex_if.stallreq);
    end
    $display("%s op=%b a=%h b=%h stall=%0d starts=%0d", name, code, a, b, stalls, starts);
  endtask

  task automatic test_reset;
    ex_if.op_valid = 1'b1;
    ex_if.op_code  = 2'b10;
    ex_if.src_a    = 32'd7;
    ex_if.src_b    = 32'd3;
    ex_if.annul    = 1'b0;
    ex_if.ex_hold  = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({ex_if.stallreq, ex_if.busy, ex_if.hilo_we, div_start, div_annul, mul_signed, div_signed} !== 7'd0 ||
        {ex_if.hi_wdata, ex_if.lo_wdata, mul_ina, mul_inb, div_opdata1, div_opdata2} !== 192'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall=%b busy=%b we=%b start=%b, expected all outputs 0",
               ex_if.stallreq, ex_if.busy, ex_if.hilo_we, div_start);
    end
    ex_if.op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ex_if.busy !== 1'b0 || ex_if.stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b stallreq=%b, expected 0 0", ex_if.busy, ex_if.stallreq);
    end
    $display("reset checked");
  endtask

  task automatic test_annul(input string name, input int nth);
    @(posedge clk); #1;
    ex_if.op_valid = 1'b1;
    ex_if.op_code  = 2'b11;
    ex_if.src_a    = 32'd1000;
    ex_if.src_b    = 32'd3;
    repeat (nth) @(posedge clk);
    #1;
    ex_if.annul = 1'b1;
    @(negedge clk);
    n_vec++;
    if (div_annul !== 1'b1 || div_start !== 1'b0 || ex_if.stallreq !== 1'b0 || ex_if.hilo_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_cycle: got div_annul=%b div_start=%b stallreq=%b we=%b, expected 1 0 0 0",
               name, div_annul, div_start, ex_if.stallreq, ex_if.hilo_we);
    end
    @(posedge clk); #1;
    ex_if.annul    = 1'b0;
    ex_if.op_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ex_if.busy !== 1'b0 || div_annul !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after: got busy=%b div_annul=%b, expected 0 0", name, ex_if.busy, div_annul);
    end
    repeat (3) @(negedge clk);
    $display("%s annul in DIV_WAIT cycle %0d", name, nth);
  endtask

  task automatic test_reset_mid_div;
    @(posedge clk); #1;
    ex_if.op_valid = 1'b1;
    ex_if.op_code  = 2'b10;
    ex_if.src_a    = 32'h1234_5678;
    ex_if.src_b    = 32'd9;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({ex_if.stallreq, ex_if.busy, div_start, div_signed} !== 4'd0 || {div_opdata1, div_opdata2} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_async: got stall=%b busy=%b start=%b opd1=%h, expected all 0",
               ex_if.stallreq, ex_if.busy, div_start, div_opdata1);
    end
    ex_if.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("reset mid DIV_WAIT checked");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] code;
      code = 2'(i);
      run_op("b2b", code, $urandom, $urandom | 32'd1, code[1] ? DIV_CYC + 2 : MUL_LAT + 1, code[1] ? DIV_CYC + 1 : 0, 0);
    end
  endtask

  initial begin
    test_reset();
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, MUL_LAT + 1, 0, 0);
    run_op("mult",  2'b00, -32'sd3, 32'd7, MUL_LAT + 1, 0, 0);
    run_op("div",   2'b10, -32'sd7, 32'd2, DIV_CYC + 2, DIV_CYC + 1, 0);
    test_annul("annul10", 10);
    run_op("divu",  2'b11, 32'd9, 32'd4, DIV_CYC + 2, DIV_CYC + 1, 0);
    test_annul("annul_ready", DIV_CYC + 1);
    run_op("divu2", 2'b11, 32'd100, 32'd7, DIV_CYC + 2, DIV_CYC + 1, 0);
    run_op("hold",  2'b01, 32'd6, 32'd7, MUL_LAT + 1, 0, 3);
    test_back_to_back();
`ifdef MULDIV_DIV_ZERO_FAST_EN
    run_op("div0",  2'b11, 32'd5, 32'd0, 1, 0, 0);
`else
    run_op("div0",  2'b11, 32'd5, 32'd0, DIV_CYC + 2, DIV_CYC + 1, 0);
`endif
    test_reset_mid_div();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
